// File: rtl/vc_qspi_mem_if.sv
// vc_qspi_mem_if: CPU burst port plus QSPI pins of the vc16 memory controller.
// Ports (slave = controller side):
//   req_valid/req_ready/req_write/req_addr[23:0]/req_len[3:0]  burst request handshake
//   wdata[15:0]/wdata_valid/wdata_ready                         write word stream
//   rdata[15:0]/rdata_valid, done, err                          read words and completion strobes
//   sclk, cs_n[1:0], io_out[3:0], io_oe[3:0], io_in[3:0]        QSPI pins on the uio bus
// master = CPU and pad side (drives requests, write words and io_in).
interface vc_qspi_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [3:0]  req_len;
    logic [15:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        done;
    logic        err;
    logic        sclk;
    logic [1:0]  cs_n;
    logic [3:0]  io_out;
    logic [3:0]  io_oe;
    logic [3:0]  io_in;
    modport master (
        output req_valid, req_write, req_addr, req_len, wdata, wdata_valid, io_in,
        input  req_ready, wdata_ready, rdata, rdata_valid, done, err, sclk, cs_n, io_out, io_oe
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid, io_in,
        output req_ready, wdata_ready, rdata, rdata_valid, done, err, sclk, cs_n, io_out, io_oe
    );
endinterface

// File: rtl/vc_qspi_mem.sv
// vc_qspi_mem: quad-SPI flash/PSRAM burst controller for the vc16 core, serial clock = clk/2.
// Ports: clk, rst_n (synchronous, active low), bus (vc_qspi_mem_if.slave: request, write
// stream, read stream, done/err strobes and QSPI pins). Addresses with bit 23 clear select
// the flash on cs_n[0], set select the PSRAM on cs_n[1].
// Build option: define VC_QSPI_WRITE_EN to compile in PSRAM quad writes; without it every
// write request is rejected with err and wdata_ready stays low.
module vc_qspi_mem #(
    parameter int DUMMY  = 6,
    parameter int CS_GAP = 2
) (
    input logic         clk,
    input logic         rst_n,
    vc_qspi_mem_if.slave bus
);
    localparam logic [7:0] READ_CMD   = 8'hEB;
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY - 1);
    localparam logic [3:0] GAP_LAST   = 4'(CS_GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_GAP} state_t;

    state_t      state;
    logic [31:0] sh;
    logic [4:0]  cnt;
    logic [3:0]  wcnt;
    logic [3:0]  gcnt;
    logic        wr;
    logic        bad;
    logic [7:0]  op;

`ifdef VC_QSPI_WRITE_EN
    localparam logic [7:0] WRITE_CMD = 8'h38;
    assign bad = bus.req_write && !bus.req_addr[23];
    assign op  = bus.req_write ? WRITE_CMD : READ_CMD;
`else
    assign bad = bus.req_write;
    assign op  = READ_CMD;
`endif

    // sclk doubles as the bit phase: low cycle presents data, high cycle lets the device
    // sample; every advance happens at the edge that ends a high cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            bus.req_ready   <= 1'b1;
            bus.cs_n        <= 2'b11;
            bus.sclk        <= 1'b0;
            bus.io_out      <= 4'b0;
            bus.io_oe       <= 4'b0;
            bus.wdata_ready <= 1'b0;
            bus.rdata       <= 16'b0;
            bus.rdata_valid <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
            sh              <= 32'b0;
            cnt             <= 5'b0;
            wcnt            <= 4'b0;
            gcnt            <= 4'b0;
            wr              <= 1'b0;
        end else begin
            bus.rdata_valid <= 1'b0;
            bus.done        <= 1'b0;
            bus.err         <= 1'b0;
`ifdef VC_QSPI_WRITE_EN
            // Waiting for a write word: serial clock parked low until the handshake.
            if (bus.wdata_ready) begin
                bus.sclk <= 1'b0;
                if (bus.wdata_valid) begin
                    bus.wdata_ready <= 1'b0;
                    state           <= S_WDATA;
                    sh              <= {bus.wdata, 16'b0};
                    bus.io_out      <= bus.wdata[15:12];
                    cnt             <= 5'd3;
                    if (state == S_WDATA) wcnt <= wcnt - 4'd1;
                end
            end else
`endif
            case (state)
                S_IDLE: if (bus.req_valid) begin
                    bus.req_ready <= 1'b0;
                    wr            <= bus.req_write;
                    wcnt          <= bus.req_len;
                    if (bad) begin
                        state    <= S_GAP;
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                        gcnt     <= GAP_LAST;
                    end else begin
                        state      <= S_CMD;
                        bus.cs_n   <= bus.req_addr[23] ? 2'b01 : 2'b10;
                        sh         <= {op, 1'b0, bus.req_addr[22:1], 1'b0};
                        bus.io_out <= {3'b0, op[7]};
                        bus.io_oe  <= 4'b0001;
                        cnt        <= 5'd7;
                    end
                end
                // Opcode bits leave sh[31] one at a time; after the last one the address
                // sits in sh[31:8] ready for nibble output.
                S_CMD: if (!bus.sclk) bus.sclk <= 1'b1;
                else begin
                    bus.sclk <= 1'b0;
                    sh       <= sh << 1;
                    cnt      <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state      <= S_ADDR;
                        bus.io_out <= sh[30:27];
                        bus.io_oe  <= 4'b1111;
                        cnt        <= 5'd5;
                    end else bus.io_out <= {3'b0, sh[30]};
                end
                S_ADDR, S_WDATA: if (!bus.sclk) begin
                    bus.sclk <= 1'b1;
`ifdef VC_QSPI_WRITE_EN
                    // Request the next word during the last high phase so it loads back to back.
                    if (wr && cnt == 5'd0 && (state == S_ADDR || wcnt != 4'd0)) bus.wdata_ready <= 1'b1;
`endif
                end else if (cnt != 5'd0) begin
                    bus.sclk   <= 1'b0;
                    bus.io_out <= sh[27:24];
                    sh         <= sh << 4;
                    cnt        <= cnt - 5'd1;
                end else if (state == S_ADDR) begin
                    bus.sclk   <= 1'b0;
                    state      <= S_DUMMY;
                    bus.io_oe  <= 4'b0;
                    bus.io_out <= 4'b0;
                    cnt        <= DUMMY_LAST;
                end else begin
                    bus.sclk   <= 1'b0;
                    state      <= S_GAP;
                    bus.cs_n   <= 2'b11;
                    bus.io_oe  <= 4'b0;
                    bus.io_out <= 4'b0;
                    bus.done   <= 1'b1;
                    gcnt       <= GAP_LAST;
                end
                S_DUMMY: if (!bus.sclk) bus.sclk <= 1'b1;
                else begin
                    bus.sclk <= 1'b0;
                    cnt      <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= S_RDATA;
                        cnt   <= 5'd3;
                    end
                end
                S_RDATA: if (!bus.sclk) bus.sclk <= 1'b1;
                else begin
                    bus.sclk <= 1'b0;
                    sh       <= {sh[27:0], bus.io_in};
                    cnt      <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        bus.rdata       <= {sh[11:0], bus.io_in};
                        bus.rdata_valid <= 1'b1;
                        cnt             <= 5'd3;
                        wcnt            <= wcnt - 4'd1;
                        if (wcnt == 4'd0) begin
                            state    <= S_GAP;
                            bus.cs_n <= 2'b11;
                            bus.done <= 1'b1;
                            gcnt     <= GAP_LAST;
                        end
                    end
                end
                S_GAP: if (gcnt == 4'd0) begin
                    state         <= S_IDLE;
                    bus.req_ready <= 1'b1;
                end else gcnt <= gcnt - 4'd1;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
